// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// State encoding, grant identifiers and default timing parameters.
package uart_tx_sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      START    = 2'd1,
      WAIT     = 2'd2,
      SEQ_NEXT = 2'd3
   } sched_state_t;

   localparam logic GNT_KB  = 1'b0;
   localparam logic GNT_SEQ = 1'b1;

   localparam int DEFAULT_BAUD_DIV      = 163;
   localparam int DEFAULT_TIMEOUT_TICKS = 16;
   localparam int DEFAULT_FIFO_DEPTH    = 4;

endpackage

// File: rtl/kb_byte_fifo.sv
// Small synchronous byte FIFO that buffers keystrokes while the transmitter is busy.
// The pop side is fall-through: pop_data always shows the head entry.
module kb_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one uart_tx between a keyboard byte source and a multi-byte sequence source.
// Define UART_TX_SCHED_KB_FIFO_EN to buffer keystrokes in a FIFO instead of stalling them.
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter int BAUD_DIV      = DEFAULT_BAUD_DIV,
   parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
   parameter int FIFO_DEPTH    = DEFAULT_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       kb_valid,
   input  logic [7:0] kb_data,
   output logic       kb_ready,
   input  logic       seq_valid,
   input  logic [7:0] seq_data,
   input  logic       seq_last,
   output logic       seq_ready,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_done_tick,
   output logic       baud_tick,
   output logic       busy,
   output logic       timeout_err
);

   if (BAUD_DIV < 2 || BAUD_DIV > 255) begin : g_bad_baud_div
      $error("uart_tx_scheduler: BAUD_DIV must be in 2..255");
   end
   if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
      $error("uart_tx_scheduler: TIMEOUT_TICKS must be in 1..255");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
      $error("uart_tx_scheduler: FIFO_DEPTH must be a power of 2, at least 2");
   end

   sched_state_t state, state_nxt;
   logic [7:0]   baud_cnt;
   logic [7:0]   tick_cnt, tick_cnt_nxt;
   logic [7:0]   tx_data_nxt;
   logic         lock, lock_nxt;
   logic         last_grant, last_grant_nxt;
   logic         timeout_nxt;
   logic         kb_req;
   logic [7:0]   kb_byte;
   logic         gnt_kb, gnt_seq;
   logic         seq_rdy;

   // Free-running divider; never stalled by the FSM.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          baud_cnt <= '0;
      else if (baud_cnt == 8'(BAUD_DIV - 1)) baud_cnt <= '0;
      else                                   baud_cnt <= baud_cnt + 8'd1;
   end

   assign baud_tick = (baud_cnt == 8'(BAUD_DIV - 1));

`ifdef UART_TX_SCHED_KB_FIFO_EN
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   kb_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (8)
   ) u_kb_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (kb_valid && kb_ready),
      .push_data (kb_data),
      .pop       ((state == IDLE) && gnt_kb),
      .pop_data  (kb_byte),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign kb_ready = reset_n && !fifo_full;
   assign kb_req   = !fifo_empty;
`else
   assign kb_req   = kb_valid;
   assign kb_byte  = kb_data;
   assign kb_ready = reset_n && (state == IDLE) && gnt_kb;
`endif

   assign seq_ready = reset_n && seq_rdy;
   assign tx_start  = (state == START);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt      = state;
      tick_cnt_nxt   = tick_cnt;
      tx_data_nxt    = tx_data;
      lock_nxt       = lock;
      last_grant_nxt = last_grant;
      timeout_nxt    = 1'b0;
      gnt_kb         = 1'b0;
      gnt_seq        = 1'b0;
      seq_rdy        = 1'b0;
      case (state)
         IDLE: begin
            // Round-robin per packet: on a tie the channel not served last wins.
            gnt_kb  = kb_req && (!seq_valid || last_grant == GNT_SEQ);
            gnt_seq = seq_valid && !gnt_kb;
            seq_rdy = gnt_seq;
            if (gnt_kb) begin
               tx_data_nxt    = kb_byte;
               last_grant_nxt = GNT_KB;
               lock_nxt       = 1'b0;
               state_nxt      = START;
            end else if (gnt_seq) begin
               tx_data_nxt    = seq_data;
               last_grant_nxt = GNT_SEQ;
               lock_nxt       = !seq_last;
               state_nxt      = START;
            end
         end
         START: begin
            tick_cnt_nxt = '0;
            state_nxt    = WAIT;
         end
         WAIT: begin
            // Done takes priority over a watchdog expiry in the same cycle.
            if (tx_done_tick) begin
               state_nxt = lock ? SEQ_NEXT : IDLE;
            end else if (baud_tick) begin
               if (tick_cnt == 8'(TIMEOUT_TICKS - 1)) begin
                  timeout_nxt = 1'b1;
                  lock_nxt    = 1'b0;
                  state_nxt   = IDLE;
               end else begin
                  tick_cnt_nxt = tick_cnt + 8'd1;
               end
            end
         end
         SEQ_NEXT: begin
            seq_rdy = 1'b1;
            if (seq_valid) begin
               tx_data_nxt = seq_data;
               lock_nxt    = !seq_last;
               state_nxt   = START;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         tx_data     <= 8'h00;
         lock        <= 1'b0;
         last_grant  <= GNT_SEQ;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         tick_cnt    <= tick_cnt_nxt;
         tx_data     <= tx_data_nxt;
         lock        <= lock_nxt;
         last_grant  <= last_grant_nxt;
         timeout_err <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration, sequence lock, watchdog, baud divider.
// The FIFO scenario runs when UART_TX_SCHED_KB_FIFO_EN is defined.
module tb_uart_tx_scheduler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       kb_valid = 1'b0;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready;
   logic       seq_valid = 1'b0;
   logic [7:0] seq_data = 8'h00;
   logic       seq_last = 1'b0;
   logic       seq_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done_tick = 1'b0;
   logic       baud_tick;
   logic       busy;
   logic       timeout_err;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] tx_log [$];

   always #5 clk = ~clk;

   uart_tx_scheduler dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .kb_valid     (kb_valid),
      .kb_data      (kb_data),
      .kb_ready     (kb_ready),
      .seq_valid    (seq_valid),
      .seq_data     (seq_data),
      .seq_last     (seq_last),
      .seq_ready    (seq_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_done_tick (tx_done_tick),
      .baud_tick    (baud_tick),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   always @(negedge clk) if (reset_n && tx_start) tx_log.push_back(tx_data);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Call right after reset_n rises at a negedge.
   task automatic baud_check(input string tag);
      int first = -1;
      int second = -1;
      int bsy = 0;
      for (int k = 1; k <= 330; k++) begin
         @(negedge clk);
         if (busy) bsy++;
         if (baud_tick) begin
            if (first < 0)       first = k;
            else if (second < 0) second = k;
         end
      end
      chk({tag, "_first"}, first, 162);
      chk({tag, "_period"}, second - first, 163);
      chk({tag, "_idle"}, bsy, 0);
   endtask

   task automatic byte_done();
      repeat (2) @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
   endtask

   task automatic kb_send(input logic [7:0] d);
      @(negedge clk);
      kb_valid = 1'b1;
      kb_data  = d;
      #1;
      for (int i = 0; i < 20 && !kb_ready; i++) begin
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      kb_valid = 1'b0;
      for (int i = 0; i < 10 && !tx_start; i++) @(negedge clk);
      #1 chk("kb_send_start", {tx_start, tx_data}, {1'b1, d});
   endtask

   task automatic seq_send(input logic [7:0] d, input logic last);
      @(negedge clk);
      seq_valid = 1'b1;
      seq_data  = d;
      seq_last  = last;
      #1;
      for (int i = 0; i < 20 && !seq_ready; i++) begin
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      seq_valid = 1'b0;
      seq_last  = 1'b0;
      #1 chk("seq_send_start", {tx_start, tx_data}, {1'b1, d});
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int ticks;
      bit seen;
`ifndef UART_TX_SCHED_KB_FIFO_EN
      logic [7:0] exp_log [9];
`endif

      // Reset state, with both sources requesting so the ready gating is visible.
      kb_valid  = 1'b1;
      kb_data   = 8'h41;
      seq_valid = 1'b1;
      seq_data  = 8'h1B;
      #23;
      chk("rst_busy", busy, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_baud_tick", baud_tick, 0);
      chk("rst_kb_ready", kb_ready, 0);
      chk("rst_seq_ready", seq_ready, 0);
      kb_valid  = 1'b0;
      seq_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      baud_check("baud");

`ifdef UART_TX_SCHED_KB_FIFO_EN
      // Keep the transmitter busy with one sequence byte, then overfill the FIFO.
      seq_send(8'h1B, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         kb_valid = 1'b1;
         kb_data  = 8'h31 + 8'(i);
         #1 chk($sformatf("fifo_ready%0d", i), kb_ready, (i < 4));
      end
      @(negedge clk);
      kb_valid = 1'b0;
      byte_done();
      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 10 && !tx_start; i++) @(negedge clk);
         #1 chk($sformatf("fifo_tx%0d", j), {tx_start, tx_data}, {1'b1, 8'h31 + 8'(j)});
         byte_done();
      end
      repeat (3) @(negedge clk);
      #1 chk("fifo_drained", busy, 0);
`else
      // Single keyboard byte: same-cycle ready, start one cycle later.
      @(negedge clk);
      kb_valid = 1'b1;
      kb_data  = 8'h41;
      #1;
      chk("kb_ready", kb_ready, 1);
      chk("kb_seq_ready", seq_ready, 0);
      chk("kb_idle_busy", busy, 0);
      @(negedge clk);
      kb_valid = 1'b0;
      #1;
      chk("kb_start", {tx_start, tx_data}, {1'b1, 8'h41});
      chk("kb_busy", busy, 1);
      @(negedge clk);
      #1 chk("kb_start_1cyc", tx_start, 0);
      @(negedge clk);
      tx_done_tick = 1'b1;
      #1 chk("kb_busy_done", busy, 1);
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1 chk("kb_idle", busy, 0);
`endif

      // Reset in the middle of a byte, with another keystroke pending.
      kb_send(8'h55);
      @(negedge clk);
      kb_valid = 1'b1;
      kb_data  = 8'h56;
      @(negedge clk);
      kb_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_baud_tick", baud_tick, 0);
      @(negedge clk);
      reset_n = 1'b1;
      baud_check("baud_rst");

`ifndef UART_TX_SCHED_KB_FIFO_EN
      // First tie after reset goes to the keyboard.
      @(negedge clk);
      kb_valid  = 1'b1;
      kb_data   = 8'h61;
      seq_valid = 1'b1;
      seq_data  = 8'h1B;
      seq_last  = 1'b1;
      #1;
      chk("tie_kb_ready", kb_ready, 1);
      chk("tie_seq_ready", seq_ready, 0);
      @(negedge clk);
      kb_valid = 1'b0;
      #1;
      chk("tie_first", {tx_start, tx_data}, {1'b1, 8'h61});
      chk("tie_seq_hold", seq_ready, 0);
      byte_done();
      chk("tie_seq_ready2", seq_ready, 1);
      @(negedge clk);
      seq_valid = 1'b0;
      #1 chk("tie_second", {tx_start, tx_data}, {1'b1, 8'h1B});
      byte_done();

      // After seq was served, the next tie goes back to the keyboard.
      @(negedge clk);
      kb_valid  = 1'b1;
      kb_data   = 8'h63;
      seq_valid = 1'b1;
      #1;
      chk("tie2_kb_ready", kb_ready, 1);
      chk("tie2_seq_ready", seq_ready, 0);
      @(negedge clk);
      kb_valid  = 1'b0;
      seq_valid = 1'b0;
      #1 chk("tie2_data", {tx_start, tx_data}, {1'b1, 8'h63});
      byte_done();

      // Locked burst ESC [ A with a keystroke waiting throughout.
      @(negedge clk);
      kb_valid  = 1'b1;
      kb_data   = 8'h62;
      seq_valid = 1'b1;
      seq_data  = 8'h1B;
      seq_last  = 1'b0;
      #1;
      chk("burst_seq_ready", seq_ready, 1);
      chk("burst_kb_ready", kb_ready, 0);
      @(negedge clk);
      seq_data = 8'h5B;
      #1 chk("burst_b0", {tx_start, tx_data}, {1'b1, 8'h1B});
      byte_done();
      chk("burst_lock_kb", kb_ready, 0);
      chk("burst_lock_seq", seq_ready, 1);
      chk("burst_lock_busy", busy, 1);
      @(negedge clk);
      seq_data = 8'h41;
      seq_last = 1'b1;
      #1 chk("burst_b1", {tx_start, tx_data}, {1'b1, 8'h5B});
      byte_done();
      chk("burst_lock_kb2", kb_ready, 0);
      @(negedge clk);
      seq_valid = 1'b0;
      seq_last  = 1'b0;
      #1 chk("burst_b2", {tx_start, tx_data}, {1'b1, 8'h41});
      byte_done();
      chk("burst_kb_ready3", kb_ready, 1);
      @(negedge clk);
      kb_valid = 1'b0;
      #1 chk("burst_b3", {tx_start, tx_data}, {1'b1, 8'h62});
      byte_done();

      exp_log = '{8'h41, 8'h55, 8'h61, 8'h1B, 8'h63, 8'h1B, 8'h5B, 8'h41, 8'h62};
      chk("log_len", tx_log.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < tx_log.size()) chk($sformatf("log%0d", i), tx_log[i], exp_log[i]);
`endif

      // Watchdog on a locked sequence byte.
      seq_send(8'h1B, 1'b0);
      ticks = 0;
      seen  = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (timeout_err)            seen = 1'b1;
         else if (baud_tick && busy) ticks++;
      end
      chk("wd_seen", seen, 1);
      chk("wd_ticks", ticks, 16);
      chk("wd_idle", busy, 0);
      @(negedge clk);
      #1 chk("wd_pulse_1cyc", timeout_err, 0);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
      chk("wd_late_done_busy", busy, 0);
      chk("wd_late_done_start", tx_start, 0);
      kb_send(8'h71);
      byte_done();
      chk("wd_lock_clear", busy, 0);

      // Done arriving on the same cycle as the 16th tick wins over the watchdog.
      seq_send(8'h2A, 1'b1);
      ticks = 0;
      for (int i = 0; i < 4000 && ticks < 16; i++) begin
         @(negedge clk);
         if (baud_tick && busy) begin
            ticks++;
            if (ticks == 16) tx_done_tick = 1'b1;
         end
      end
      chk("race_ticks", ticks, 16);
      @(negedge clk);
      tx_done_tick = 1'b0;
      #1;
      chk("race_no_err", timeout_err, 0);
      chk("race_idle", busy, 0);
      @(negedge clk);
      #1 chk("race_no_err2", timeout_err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
